// File: rtl/scroll_pkg.sv
// Shared constants and types for the keyboard scroll/flip controller.
package scroll_pkg;

   // Default framebuffer geometry
   localparam int H_RES_DEF = 320;
   localparam int V_RES_DEF = 240;

   // PS/2 scan codes, bit 8 is the extended-prefix flag
   localparam logic [8:0] KEY_W = 9'h1D;
   localparam logic [8:0] KEY_S = 9'h1B;
   localparam logic [8:0] KEY_A = 9'h1C;
   localparam logic [8:0] KEY_D = 9'h23;
   localparam logic [8:0] KEY_P = 9'h4D;
   localparam logic [8:0] KEY_H = 9'h33;
   localparam logic [8:0] KEY_V = 9'h2A;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MOVE  = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up/down modulo counter; steps by STEP when enabled and wraps inside 0..MOD-1
// without ever forming a value outside that range.
module wrap_counter #(
   parameter int MOD  = 320,
   parameter int W    = 9,
   parameter int STEP = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] STEP_V = W'(STEP);
   localparam logic [W-1:0] TOP_V  = W'(MOD - STEP);

   logic [W-1:0] cnt_nx;

   // Next value: compare against the wrap threshold before adding/subtracting
   always_comb begin
      cnt_nx = cnt;
      if (up) begin
         cnt_nx = (cnt >= TOP_V) ? (cnt - TOP_V) : (cnt + STEP_V);
      end else begin
         cnt_nx = (cnt < STEP_V) ? (cnt + TOP_V) : (cnt - STEP_V);
      end
   end

   // Counter register, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt_nx;
      end
   end

endmodule

// File: rtl/scroll_ctrl.sv
// Keyboard scroll/flip controller: mode FSM, held-key tracking, pending
// flip toggles, and two wrap counters for the X/Y scroll offsets.
module scroll_ctrl
   import scroll_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF,
   parameter int STEP  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [8:0] last_change,
   input  logic       make,
   input  logic       tick,
   output logic [8:0] x_off,
   output logic [7:0] y_off,
   output logic       hflip,
   output logic       vflip,
   output logic       paused,
   output logic [1:0] dir
);

   state_t     state_q, state_nx;
   dir_t       dir_q, dir_nx;
   logic [3:0] held_q, held_nx;
   logic       p_held_q, p_held_nx;
   logic       h_held_q, h_held_nx;
   logic       v_held_q, v_held_nx;
   logic       pend_h_q, pend_h_nx;
   logic       pend_v_q, pend_v_nx;
   logic       hflip_q, hflip_nx;
   logic       vflip_q, vflip_nx;

   logic       is_dir, is_p, is_h, is_v;
   dir_t       key_dir;

   // Classify the incoming scan code
   always_comb begin
      is_dir  = 1'b0;
      is_p    = 1'b0;
      is_h    = 1'b0;
      is_v    = 1'b0;
      key_dir = DIR_UP;
      case (last_change)
         KEY_W:   begin is_dir = 1'b1; key_dir = DIR_UP;    end
         KEY_S:   begin is_dir = 1'b1; key_dir = DIR_DOWN;  end
         KEY_A:   begin is_dir = 1'b1; key_dir = DIR_LEFT;  end
         KEY_D:   begin is_dir = 1'b1; key_dir = DIR_RIGHT; end
         KEY_P:   is_p = 1'b1;
         KEY_H:   is_h = 1'b1;
         KEY_V:   is_v = 1'b1;
         default: ;
      endcase
   end

   // Next-state logic; a make for an already-held key is treated as typematic
   // repeat and ignored. A tick consumes the pending flips before any flip
   // press of the same cycle re-arms them.
   always_comb begin
      state_nx  = state_q;
      dir_nx    = dir_q;
      held_nx   = held_q;
      p_held_nx = p_held_q;
      h_held_nx = h_held_q;
      v_held_nx = v_held_q;
      pend_h_nx = tick ? 1'b0 : pend_h_q;
      pend_v_nx = tick ? 1'b0 : pend_v_q;
      hflip_nx  = hflip_q ^ (tick & pend_h_q);
      vflip_nx  = vflip_q ^ (tick & pend_v_q);

      if (key_valid) begin
         if (is_dir) begin
            held_nx[key_dir] = make;
            if (make && !held_q[key_dir]) begin
               dir_nx = key_dir;
               if (state_q == ST_IDLE) begin
                  state_nx = ST_MOVE;
               end
            end else if (!make && (state_q == ST_MOVE) && (key_dir == dir_q)) begin
               state_nx = ST_IDLE;
            end
         end
         if (is_p) begin
            p_held_nx = make;
            if (make && !p_held_q) begin
               if (state_q == ST_PAUSE) begin
                  state_nx = (|held_q) ? ST_MOVE : ST_IDLE;
               end else begin
                  state_nx = ST_PAUSE;
               end
            end
         end
         if (is_h) begin
            h_held_nx = make;
            if (make && !h_held_q) begin
               pend_h_nx = ~pend_h_nx;
            end
         end
         if (is_v) begin
            v_held_nx = make;
            if (make && !v_held_q) begin
               pend_v_nx = ~pend_v_nx;
            end
         end
      end
   end

   // Control and flip registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         dir_q    <= DIR_UP;
         held_q   <= '0;
         p_held_q <= 1'b0;
         h_held_q <= 1'b0;
         v_held_q <= 1'b0;
         pend_h_q <= 1'b0;
         pend_v_q <= 1'b0;
         hflip_q  <= 1'b0;
         vflip_q  <= 1'b0;
      end else begin
         state_q  <= state_nx;
         dir_q    <= dir_nx;
         held_q   <= held_nx;
         p_held_q <= p_held_nx;
         h_held_q <= h_held_nx;
         v_held_q <= v_held_nx;
         pend_h_q <= pend_h_nx;
         pend_v_q <= pend_v_nx;
         hflip_q  <= hflip_nx;
         vflip_q  <= vflip_nx;
      end
   end

   // Offsets advance only in MOVE, using the pre-event state and direction
   logic step_en, x_en, y_en;
   assign step_en = tick && (state_q == ST_MOVE);
   assign x_en    = step_en && ((dir_q == DIR_LEFT) || (dir_q == DIR_RIGHT));
   assign y_en    = step_en && ((dir_q == DIR_UP) || (dir_q == DIR_DOWN));

   wrap_counter #(.MOD(H_RES), .W(9), .STEP(STEP)) u_x_cnt (
      .clk (clk),
      .rst (rst),
      .en  (x_en),
      .up  (dir_q == DIR_LEFT),
      .cnt (x_off)
   );

   wrap_counter #(.MOD(V_RES), .W(8), .STEP(STEP)) u_y_cnt (
      .clk (clk),
      .rst (rst),
      .en  (y_en),
      .up  (dir_q == DIR_UP),
      .cnt (y_off)
   );

   assign hflip  = hflip_q;
   assign vflip  = vflip_q;
   assign paused = (state_q == ST_PAUSE);
   assign dir    = dir_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Scoreboard bench for scroll_ctrl: driver feeds a behavioural model that
// queues expected outputs; a monitor pops and compares after every edge.
module tb_scroll_ctrl;

   localparam int H_RES = 320;
   localparam int V_RES = 240;
   localparam int STEP  = 1;

   localparam logic [8:0] K_W = 9'h1D, K_S = 9'h1B, K_A = 9'h1C, K_D = 9'h23;
   localparam logic [8:0] K_P = 9'h4D, K_H = 9'h33, K_V = 9'h2A;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [8:0] last_change = '0;
   logic       make = 1'b0;
   logic       tick = 1'b0;
   logic [8:0] x_off;
   logic [7:0] y_off;
   logic       hflip, vflip, paused;
   logic [1:0] dir;

   scroll_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .STEP(STEP)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .last_change (last_change),
      .make        (make),
      .tick        (tick),
      .x_off       (x_off),
      .y_off       (y_off),
      .hflip       (hflip),
      .vflip       (vflip),
      .paused      (paused),
      .dir         (dir)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic       hf;
      logic       vf;
      logic       pa;
      logic [1:0] d;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   // Reference model: mode 0 idle, 1 moving, 2 paused; plain integer arithmetic
   int m_mode, m_dir, m_x, m_y;
   bit m_held[4];
   bit m_ph, m_hh, m_vh, m_pend_h, m_pend_v, m_hf, m_vf;

   function automatic int dir_of(input logic [8:0] c);
      if (c == K_W) return 0;
      if (c == K_S) return 1;
      if (c == K_A) return 2;
      if (c == K_D) return 3;
      return -1;
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_dir = 0; m_x = 0; m_y = 0;
      for (int i = 0; i < 4; i++) m_held[i] = 0;
      m_ph = 0; m_hh = 0; m_vh = 0; m_pend_h = 0; m_pend_v = 0; m_hf = 0; m_vf = 0;
   endfunction

   function automatic void model_step(input bit kv, input logic [8:0] code, input bit mk, input bit tk);
      int  kd;
      bit  any_held;
      exp_t e;
      if (tk) begin
         if (m_mode == 1) begin
            case (m_dir)
               0: m_y = (m_y + STEP) % V_RES;
               1: m_y = (m_y + V_RES - STEP) % V_RES;
               2: m_x = (m_x + STEP) % H_RES;
               default: m_x = (m_x + H_RES - STEP) % H_RES;
            endcase
         end
         if (m_pend_h) m_hf = !m_hf;
         if (m_pend_v) m_vf = !m_vf;
         m_pend_h = 0;
         m_pend_v = 0;
      end
      if (kv) begin
         kd = dir_of(code);
         if (kd >= 0) begin
            if (mk && !m_held[kd]) begin
               m_dir = kd;
               if (m_mode == 0) m_mode = 1;
            end else if (!mk && m_mode == 1 && kd == m_dir) begin
               m_mode = 0;
            end
            m_held[kd] = mk;
         end else if (code == K_P) begin
            if (mk && !m_ph) begin
               any_held = 0;
               for (int i = 0; i < 4; i++) any_held |= m_held[i];
               if (m_mode == 2) m_mode = any_held ? 1 : 0;
               else m_mode = 2;
            end
            m_ph = mk;
         end else if (code == K_H) begin
            if (mk && !m_hh) m_pend_h = !m_pend_h;
            m_hh = mk;
         end else if (code == K_V) begin
            if (mk && !m_vh) m_pend_v = !m_pend_v;
            m_vh = mk;
         end
      end
      e.x  = 9'(m_x);
      e.y  = 8'(m_y);
      e.hf = m_hf;
      e.vf = m_vf;
      e.pa = (m_mode == 2);
      e.d  = 2'(m_dir);
      sbq.push_back(e);
   endfunction

   // Monitor: compare every registered output one step after each edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("x_off",  int'(x_off),  int'(e.x));
         check("y_off",  int'(y_off),  int'(e.y));
         check("hflip",  int'(hflip),  int'(e.hf));
         check("vflip",  int'(vflip),  int'(e.vf));
         check("paused", int'(paused), int'(e.pa));
         check("dir",    int'(dir),    int'(e.d));
      end
   end

   // One clock of stimulus, starting and ending at a falling edge
   task automatic cyc(input bit kv, input logic [8:0] code, input bit mk, input bit tk);
      key_valid   = kv;
      last_change = code;
      make        = mk;
      tick        = tk;
      model_step(kv, code, mk, tk);
      @(negedge clk);
   endtask

   task automatic press(input logic [8:0] c);   cyc(1'b1, c, 1'b1, 1'b0); endtask
   task automatic release_k(input logic [8:0] c); cyc(1'b1, c, 1'b0, 1'b0); endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 9'h000, 1'b0, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_x"},  int'(x_off),  0);
      check({tag, "_y"},  int'(y_off),  0);
      check({tag, "_hf"}, int'(hflip),  0);
      check({tag, "_vf"}, int'(vflip),  0);
      check({tag, "_pa"}, int'(paused), 0);
      check({tag, "_d"},  int'(dir),    0);
   endtask

   logic [8:0] codes [9];

   initial begin
      codes[0] = K_W; codes[1] = K_S; codes[2] = K_A; codes[3] = K_D;
      codes[4] = K_P; codes[5] = K_H; codes[6] = K_V;
      codes[7] = 9'h015; codes[8] = 9'h11D;
      model_reset();

      // Reset held with ticks running
      @(negedge clk);
      tick = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("rst");
      tick = 1'b0;
      rst  = 1'b1;

      // Ticks in IDLE keep offsets at zero
      ticks(4);
      check("idle_y", int'(y_off), 0);
      check("idle_x", int'(x_off), 0);

      // Upward scroll and wrap at the top
      press(K_W);
      ticks(239);
      check("up_239", int'(y_off), 239);
      ticks(1);
      check("up_wrap", int'(y_off), 0);
      release_k(K_W);
      ticks(1);
      check("idle_hold", int'(y_off), 0);

      // Reverse wrap on X, then direction change while D held
      press(K_D);
      ticks(1);
      check("right_wrap", int'(x_off), 319);
      press(K_A);
      check("dir_left", int'(dir), 2);
      ticks(1);
      check("left_wrap", int'(x_off), 0);
      release_k(K_A);
      release_k(K_D);

      // Pause, typematic P, resume
      press(K_S);
      ticks(3);
      check("down_3", int'(y_off), 237);
      press(K_P);
      check("paused_on", int'(paused), 1);
      ticks(5);
      check("pause_hold", int'(y_off), 237);
      press(K_P); press(K_P); press(K_P);
      check("p_repeat", int'(paused), 1);
      release_k(K_P);
      press(K_P);
      check("resumed", int'(paused), 0);
      ticks(1);
      check("resume_step", int'(y_off), 236);
      release_k(K_S);
      release_k(K_P);

      // Flip gating and cancellation
      press(K_H);
      check("hflip_wait", int'(hflip), 0);
      ticks(1);
      check("hflip_set", int'(hflip), 1);
      release_k(K_H);
      press(K_V); release_k(K_V); press(K_V);
      ticks(1);
      check("vflip_cancel", int'(vflip), 0);
      release_k(K_V);

      // Direction press coincident with a tick from IDLE
      cyc(1'b1, K_A, 1'b1, 1'b1);
      check("same_cyc", int'(x_off), 0);
      ticks(1);
      check("next_tick", int'(x_off), 1);
      release_k(K_A);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) < 35, codes[$urandom_range(0, 8)],
             $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40);
      end

      // Asynchronous reset in the middle of a step
      key_valid = 1'b0;
      tick      = 1'b1;
      #2 rst = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk);
      rst  = 1'b1;
      tick = 1'b0;
      model_reset();
      sbq.delete();

      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(0, 99) < 35, codes[$urandom_range(0, 8)],
             $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40);
      end

      @(negedge clk);
      check("sb_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scroll_ctrl.md
# scroll_ctrl

Keyboard-driven scroll and flip controller for the 320x240 framebuffer display path. Consumes decoded PS/2 make/break events and a per-step strobe. Keeps the display mode state: direction, pause and flips. Produces wrapped X/Y scroll offsets and registered flip flags for the pixel address generator, and owns all sequencing of scroll motion.

## Interface
Parameters:
- H_RES, 320: image width in pixels; x offset range 0..H_RES-1
- V_RES, 240: image height in pixels; y offset range 0..V_RES-1
- STEP, 1: pixels moved per tick; must be < min(H_RES, V_RES)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- key_valid  in  1  one-cycle strobe; a decoded key event is present
- last_change  in  9  scan code of the event, with extended-prefix bit at [8]
- make  in  1  qualified by key_valid; 1 = press, 0 = release
- tick  in  1  one-cycle scroll-step strobe (frame or divided clock)
- x_off  out  9  horizontal scroll offset, registered
- y_off  out  8  vertical scroll offset, registered
- hflip  out  1  horizontal mirror enable, registered
- vflip  out  1  vertical mirror enable, registered
- paused  out  1  high while in PAUSE
- dir  out  2  active direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT

## Operation
Key codes:
- W 9'h1D, S 9'h1B, A 9'h1C, D 9'h23: direction keys
- P 9'h4D: pause toggle
- H 9'h33: hflip toggle
- V 9'h2A: vflip toggle
- All other codes are ignored.

FSM states: IDLE, MOVE, PAUSE.
- IDLE:
  - Direction press: latch dir, go to MOVE.
  - P press: go to PAUSE.
- MOVE:
  - Release of the key matching the current dir: go to IDLE.
  - Press of a different direction key: relatch dir, stay in MOVE.
  - P press: go to PAUSE.
- PAUSE:
  - Direction presses still relatch dir; releases are ignored.
  - P press: go to MOVE if a direction key is held, else IDLE.
  - Held-key tracking uses 4 internal bits, updated on every make/break, in every state.
- Typematic repeat: a make for a key already held is ignored. A repeated P must not retoggle pause.
- Releases of P, H and V have no effect.

Offset update, on tick in MOVE only:
- UP: y_off = (y_off + STEP) mod V_RES
- DOWN: y_off = (y_off − STEP) mod V_RES
- LEFT: x_off = (x_off + STEP) mod H_RES
- RIGHT: x_off = (x_off − STEP) mod H_RES
- Wrap is computed without overflow. At y_off = V_RES−1 with UP and STEP=1, the next value is 0. At x_off = 0 with RIGHT and STEP=1, the next value is H_RES−1.

Flips:
- H or V press sets a pending toggle bit.
- On the next tick, in any state, the pending bit is applied to hflip/vflip and cleared. Flips therefore never change mid-step.
- Two presses before one tick cancel out (pending bit toggles).

## Timing
- Reset (rst low, async) forces: x_off=0, y_off=0, hflip=0, vflip=0, paused=0, dir=0, state IDLE, held bits and pending bits 0.
- Release is synchronous to clk.
- A key event takes effect on the clk edge that samples key_valid. New state, dir and paused are visible the following cycle.
- Offsets and flips update on the edge that samples tick. Latency is 1 cycle.
- Simultaneous key_valid and tick:
  - The tick uses the pre-event state and dir.
  - A flip press in the same cycle as a tick is not applied by that tick; it waits for the next one.
- tick while not in MOVE: offsets hold.
- tick with no pending flip: flips hold.
- Reset asserted mid-step: all outputs return to reset values immediately. Pending events are lost.

## Structure
- Package scroll_pkg holds:
  - the key-code constants
  - the dir encoding (UP/DOWN/LEFT/RIGHT)
  - the FSM state enum
  - default H_RES/V_RES
- Sub-module wrap_counter #(MOD, W, STEP): up/down modulo counter with en, up, async active-low reset. It is instantiated twice, for x and y.
- FSM, held-key tracking and flip-pending logic live in scroll_ctrl.

## Test plan
- Reset: rst low with ticks running → all outputs 0, state IDLE. Ticks in IDLE leave x_off=y_off=0.
- Move/wrap:
  - W press, then 240 ticks → y_off steps 1,2,…,239, then 0.
  - W release → IDLE; the next tick leaves y_off unchanged.
- Reverse wrap: D press at x_off=0, 1 tick → x_off=319. A press while D is held → dir=LEFT; the next tick gives x_off=0.
- Pause/typematic:
  - S held plus 3 ticks → y_off=237.
  - P press → paused=1; 5 ticks → y_off stays 237.
  - Repeated P makes without a break → still paused.
  - P break, then P press → MOVE; the next tick gives y_off=236.
- Flip gating:
  - H press → hflip stays 0 until the next tick, then 1.
  - V press twice before a tick → vflip unchanged.
- Same-cycle: A press coincident with a tick from IDLE → x_off unchanged that tick; the following tick gives x_off=1.
